adder_share_sched: RTL and testbench
====================================

# adder_share_sched

Round-robin scheduler that shares a single 16-bit carry-select adder among `NREQ` requesters, each issuing multi-word additions. Each accepted operation is sequenced one 16-bit word per cycle, least-significant first. The carry is held in a register between words, giving an `WORDS*16`-bit add on the one shared adder. The block sits between the requesting engines and the `carry_select_adder_16bit` datapath.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `WORDS`, 4: 16-bit words per operation (1..8); operand width is `WORDS*16`.

Ports:
- `clk`, input, 1: single clock; all state on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `NREQ`: request from requester i.
- `req_ready`, output, `NREQ`: acceptance, one-hot or zero.
- `req_a`, input, `NREQ*WORDS*16`: operand A; requester i at slice `[i*WORDS*16 +: WORDS*16]`.
- `req_b`, input, `NREQ*WORDS*16`: operand B, same packing as `req_a`.
- `req_cin`, input, `NREQ`: carry-in per requester.
- `rsp_valid`, output, 1: result available.
- `rsp_ready`, input, 1: consumer accepts the result.
- `rsp_id`, output, `$clog2(NREQ)`: index of the requester that owns the result.
- `rsp_sum`, output, `WORDS*16`: sum.
- `rsp_cout`, output, 1: final carry-out.
- `rsp_ovf`, output, 1: signed overflow; present only with `ADDER_OVF_FLAG_EN`.

## Operation
FSM states are `IDLE`, `RUN` and `DONE`.

`IDLE`:
- Grant goes to the first asserted `req_valid` at or after `rr_ptr`, searching upward with wrap.
- `req_ready[g]` is combinational and asserted only in `IDLE`, only for the granted g.
- On the handshake, capture `req_a`, `req_b` and `req_cin` of g into operand registers.
- Set `carry_q` to `req_cin[g]` and `idx` to 0, latch the owner into `rsp_id`, then go to `RUN`.
- With no `req_valid` asserted, stay in `IDLE` with all `req_ready` at 0.

`RUN`, one word per cycle:
- Adder inputs are `a_q[idx]`, `b_q[idx]` and `carry_q`.
- The sum word is written to `sum_q[idx]`, `carry_q` takes the adder cout, and `idx` increments.
- When `idx==WORDS-1`, go to `DONE`; `rsp_cout` is the final carry.

`DONE`:
- `rsp_valid` is 1 and `rsp_sum`, `rsp_id`, `rsp_cout` are stable.
- On `rsp_valid & rsp_ready`, go to `IDLE` and set `rr_ptr` to `(rsp_id+1) mod NREQ`.

Handshake and arithmetic rules:
- A requester holds `req_valid` and its data stable until `req_ready`.
- `rsp_valid` never drops without `rsp_ready`.
- The adder is unsigned modulo 2^(`WORDS*16`); `rsp_cout` is bit `WORDS*16`.

## Timing
- Reset values: `req_ready` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_sum` 0, `rsp_cout` 0, `rsp_ovf` 0. Also `rr_ptr` 0, `idx` 0, state `IDLE`.
- Latency: accept at cycle T, `RUN` occupies T+1..T+WORDS, and `rsp_valid` is first high in T+WORDS+1.
- Maximum throughput is one operation per `WORDS+2` cycles with `rsp_ready` tied high. The `IDLE` cycle after `DONE` is mandatory.
- A backpressured result (`rsp_ready` low) stalls the block in `DONE`; no new request is accepted.
- Simultaneous requests: exactly one is granted per operation, and rotation guarantees each requester is served within `NREQ` operations.
- A requester that drops `req_valid` while not granted is legal and has no effect.
- Asserting `rst_n` low mid-`RUN` or in `DONE` discards the operation; all outputs and state return to reset values asynchronously.
- `WORDS=1` gives one `RUN` cycle, with result valid at T+2.

## Configuration
- `ADDER_OVF_FLAG_EN` defined:
  - The `rsp_ovf` port exists.
  - In the last `RUN` cycle, `ovf_q` is computed as `(a_msb==b_msb) && (sum_msb!=a_msb)` on bit `WORDS*16-1`.
  - It is presented with `rsp_sum` and is 0 at reset.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `adder_sched_pkg` holds:
  - the state enum (`IDLE`, `RUN`, `DONE`);
  - the word width constant `ADD_W=16`;
  - an `idx`-width helper function.
- Sub-module `rr_arbiter`: `NREQ`-wide request vector plus `rr_ptr` in, one-hot grant out, purely combinational.
- The datapath is one `carry_select_adder_16bit` instance; no other adder is inferred.

## Test plan
- Single request, `NREQ=4`, `WORDS=4`:
  - Stimulus: requester 2, `a=0x0000_0000_0000_FFFF`, `b=0x1`, `cin=0`.
  - Response: `rsp_sum=0x0000_0000_0001_0000`, `rsp_cout=0`, `rsp_id=2`, `rsp_valid` at T+5.
- Full carry ripple: `a=0xFFFF_FFFF_FFFF_FFFF`, `b=0`, `cin=1` -> `rsp_sum=0`, `rsp_cout=1`.
- All four requesters valid continuously with `rsp_ready=1`:
  - Grants are 0,1,2,3,0 in order.
  - Accept cycles are spaced 6 cycles apart.
- Backpressure: hold `rsp_ready=0` for 10 cycles in `DONE`.
  - `rsp_*` outputs are stable and all `req_ready` stay 0.
  - Release `rsp_ready`; the next grant follows one cycle after the response handshake.
- Reset mid-operation: pulse `rst_n` low during the `RUN` cycle where `idx=2`.
  - All outputs go to 0 and `rr_ptr` goes to 0.
  - A re-issued request completes correctly.
- `ADDER_OVF_FLAG_EN` with `WORDS=1`:
  - `a=0x7FFF`, `b=0x0001` -> `rsp_ovf=1`, `rsp_cout=0`.
  - `a=0xFFFF`, `b=0x0001` -> `rsp_ovf=0`, `rsp_cout=1`.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the adder-sharing scheduler.
package adder_sched_pkg;

    localparam int ADD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, searching upward with wrap.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int off = 0; off < N; off++) begin
            j = int'(ptr) + off;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/carry_select_adder_16bit.sv
// 16-bit carry-select adder built from four 4-bit blocks with precomputed carry-0/carry-1 sums.
module carry_select_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar k = 0; k < 4; k++) begin : g_blk
        logic [4:0] s0;
        logic [4:0] s1;

        assign s0 = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]};
        assign s1 = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + 5'd1;
        assign sum[4*k +: 4] = c[k] ? s1[3:0] : s0[3:0];
        assign c[k+1]        = c[k] ? s1[4]   : s0[4];
    end

    assign cout = c[4];

endmodule

// File: rtl/adder_share_sched.sv
// Round-robin scheduler sharing one 16-bit carry-select adder for multi-word adds.
// Optional signed-overflow output enabled by defining ADDER_OVF_FLAG_EN.
//   state | meaning
//   IDLE  | arbitrate, accept one request
//   RUN   | add one word per cycle, LSW first
//   DONE  | hold result until consumer accepts
module adder_share_sched
    import adder_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*WORDS*16-1:0]    req_a,
    input  logic [NREQ*WORDS*16-1:0]    req_b,
    input  logic [NREQ-1:0]             req_cin,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NREQ)-1:0]     rsp_id,
    output logic [WORDS*16-1:0]         rsp_sum,
    output logic                        rsp_cout
`ifdef ADDER_OVF_FLAG_EN
    ,
    output logic                        rsp_ovf
`endif
);

    localparam int OW = WORDS * ADD_W;
    localparam int IW = idx_w(WORDS);
    localparam int GW = idx_w(NREQ);

    state_t state_q, state_d;

    logic [NREQ-1:0]                grant;
    logic [GW-1:0]                  gidx;
    logic [GW-1:0]                  rr_ptr;
    logic [GW-1:0]                  id_q;
    logic [IW-1:0]                  idx_q;
    logic [WORDS-1:0][ADD_W-1:0]    a_q, b_q, sum_q;
    logic                           carry_q, cout_q;
    logic                           load, step, last_word;
    logic [ADD_W-1:0]               add_sum;
    logic                           add_cout;

    rr_arbiter #(.N(NREQ), .PW(GW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    carry_select_adder_16bit u_add (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) gidx = GW'(i);
        end
    end

    assign last_word = (idx_q == IW'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (|req_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_word) state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            id_q    <= '0;
            rr_ptr  <= '0;
        end else begin
            if (load) begin
                a_q     <= req_a[gidx*OW +: OW];
                b_q     <= req_b[gidx*OW +: OW];
                carry_q <= req_cin[gidx];
                idx_q   <= '0;
                id_q    <= gidx;
            end
            if (step) begin
                sum_q[idx_q] <= add_sum;
                carry_q      <= add_cout;
                idx_q        <= last_word ? '0 : idx_q + IW'(1);
                if (last_word) cout_q <= add_cout;
            end
            // Rotation advances only when a result is actually consumed.
            if (state_q == DONE && rsp_ready)
                rr_ptr <= (id_q == GW'(NREQ - 1)) ? '0 : id_q + GW'(1);
        end
    end

`ifdef ADDER_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (step && last_word) begin
            ovf_q <= (a_q[idx_q][ADD_W-1] == b_q[idx_q][ADD_W-1]) &&
                     (add_sum[ADD_W-1] != a_q[idx_q][ADD_W-1]);
        end
    end

    assign rsp_ovf = ovf_q;
`endif

    assign rsp_id   = id_q;
    assign rsp_sum  = sum_q;
    assign rsp_cout = cout_q;

endmodule

// File: tb/tb_adder_share_sched.sv
// Self-checking bench for adder_share_sched against a whole-operand arithmetic model.
module tb_adder_share_sched;

    localparam int NREQ  = 4;
    localparam int WORDS = 4;
    localparam int OW    = WORDS * 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*OW-1:0]     req_a = '0;
    logic [NREQ*OW-1:0]     req_b = '0;
    logic [NREQ-1:0]        req_cin = '0;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [1:0]             rsp_id;
    logic [OW-1:0]          rsp_sum;
    logic                   rsp_cout;
`ifdef ADDER_OVF_FLAG_EN
    logic                   rsp_ovf;
`endif

    always #5 clk = ~clk;

    adder_share_sched #(.NREQ(NREQ), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef ADDER_OVF_FLAG_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    logic [OW-1:0] a_m [NREQ];
    logic [OW-1:0] b_m [NREQ];
    logic [NREQ-1:0] taken = '0;

    int nchk = 0, nerr = 0;
    int cyc = 0, t_acc = 0, rr_m = 0, rsp_first = 0, hs_cyc = 0, n_done = 0;
    int last_lat = 0;
    bit busy = 0, keep_valid = 0, seen_rsp = 0;
    int exp_id = 0;
    logic [OW-1:0] exp_sum = '0, last_sum = '0;
    logic exp_cout = 0, exp_ovf = 0, last_cout = 0;
    logic [1:0] last_id = '0;
    int acc_log[$];
    int grant_log[$];

    task automatic drive_bus();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*OW +: OW] = a_m[i];
            req_b[i*OW +: OW] = b_m[i];
        end
    endtask

    task automatic new_data(input int i);
        a_m[i] = {$urandom, $urandom};
        b_m[i] = {$urandom, $urandom};
        req_cin[i] = 1'($urandom % 2);
        if ($urandom % 5 == 0) a_m[i] = ~b_m[i];
    endtask

    task automatic tick_drive();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (taken[i]) begin
                taken[i] = 1'b0;
                if (keep_valid) new_data(i);
                else req_valid[i] = 1'b0;
            end
        end
    endtask

    // Checks one cycle: grant choice, response timing and response contents.
    task automatic sample();
        logic [NREQ-1:0] er;
        logic [OW:0] full;
        bit ev;
        int g;
        drive_bus();
        #1;
        cyc++;
        er = '0;
        g = 0;
        if (!busy) begin
            for (int off = 0; off < NREQ; off++) begin
                int j;
                j = (rr_m + off) % NREQ;
                if (req_valid[j] && er == '0) begin
                    er[j] = 1'b1;
                    g = j;
                end
            end
        end
        nchk++;
        if (req_ready !== er) begin
            nerr++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er);
        end
        ev = busy && (cyc >= t_acc + WORDS + 1);
        nchk++;
        if (rsp_valid !== ev) begin
            nerr++;
            $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev);
        end
        if (busy && rsp_valid === 1'b1 && !seen_rsp) begin
            seen_rsp = 1;
            rsp_first = cyc;
        end
        if (ev && rsp_valid === 1'b1) begin
            nchk++;
            if (rsp_id !== 2'(exp_id)) begin
                nerr++;
                $display("FAIL rsp_id cyc=%0d got=%0d exp=%0d", cyc, rsp_id, exp_id);
            end
            nchk++;
            if (rsp_sum !== exp_sum) begin
                nerr++;
                $display("FAIL rsp_sum cyc=%0d got=%h exp=%h", cyc, rsp_sum, exp_sum);
            end
            nchk++;
            if (rsp_cout !== exp_cout) begin
                nerr++;
                $display("FAIL rsp_cout cyc=%0d got=%b exp=%b", cyc, rsp_cout, exp_cout);
            end
`ifdef ADDER_OVF_FLAG_EN
            nchk++;
            if (rsp_ovf !== exp_ovf) begin
                nerr++;
                $display("FAIL rsp_ovf cyc=%0d got=%b exp=%b", cyc, rsp_ovf, exp_ovf);
            end
`endif
            if (rsp_ready) begin
                busy      = 0;
                rr_m      = (exp_id + 1) % NREQ;
                last_sum  = rsp_sum;
                last_cout = rsp_cout;
                last_id   = rsp_id;
                last_lat  = rsp_first - t_acc;
                hs_cyc    = cyc;
                n_done++;
            end
        end
        if (er != '0) begin
            busy     = 1;
            t_acc    = cyc;
            seen_rsp = 0;
            full     = {1'b0, a_m[g]} + {1'b0, b_m[g]} + {{OW{1'b0}}, req_cin[g]};
            exp_sum  = full[OW-1:0];
            exp_cout = full[OW];
            exp_ovf  = (a_m[g][OW-1] == b_m[g][OW-1]) && (full[OW-1] != a_m[g][OW-1]);
            exp_id   = g;
            taken[g] = 1'b1;
            acc_log.push_back(cyc);
            grant_log.push_back(g);
        end
    endtask

    task automatic cycle();
        tick_drive();
        sample();
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            cycle();
            n++;
        end
        if (busy) begin
            nchk++;
            nerr++;
            $display("FAIL wait_idle timeout after %0d cycles", max);
            busy = 0;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        nchk++;
        if (req_ready !== '0) begin nerr++; $display("FAIL %s req_ready got=%b exp=0", tag, req_ready); end
        nchk++;
        if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL %s rsp_valid got=%b exp=0", tag, rsp_valid); end
        nchk++;
        if (rsp_id !== '0) begin nerr++; $display("FAIL %s rsp_id got=%0d exp=0", tag, rsp_id); end
        nchk++;
        if (rsp_sum !== '0) begin nerr++; $display("FAIL %s rsp_sum got=%h exp=0", tag, rsp_sum); end
        nchk++;
        if (rsp_cout !== 1'b0) begin nerr++; $display("FAIL %s rsp_cout got=%b exp=0", tag, rsp_cout); end
`ifdef ADDER_OVF_FLAG_EN
        nchk++;
        if (rsp_ovf !== 1'b0) begin nerr++; $display("FAIL %s rsp_ovf got=%b exp=0", tag, rsp_ovf); end
`endif
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_m[i] = '0;
            b_m[i] = '0;
        end
        drive_bus();
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_single(input int id, input logic [OW-1:0] a, input logic [OW-1:0] b,
                              input logic cin);
        tick_drive();
        a_m[id] = a;
        b_m[id] = b;
        req_cin[id] = cin;
        req_valid = '0;
        req_valid[id] = 1'b1;
        rsp_ready = 1'b1;
        keep_valid = 0;
        sample();
        wait_idle(20);
    endtask

    task automatic test_single();
        run_single(2, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        nchk++;
        if (last_sum !== 64'h0000_0000_0001_0000) begin nerr++; $display("FAIL single_sum got=%h exp=10000", last_sum); end
        nchk++;
        if (last_cout !== 1'b0) begin nerr++; $display("FAIL single_cout got=%b exp=0", last_cout); end
        nchk++;
        if (last_id !== 2'd2) begin nerr++; $display("FAIL single_id got=%0d exp=2", last_id); end
        nchk++;
        if (last_lat != WORDS + 1) begin nerr++; $display("FAIL single_latency got=%0d exp=%0d", last_lat, WORDS + 1); end
    endtask

    task automatic test_ripple();
        run_single(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        nchk++;
        if (last_sum !== 64'h0) begin nerr++; $display("FAIL ripple_sum got=%h exp=0", last_sum); end
        nchk++;
        if (last_cout !== 1'b1) begin nerr++; $display("FAIL ripple_cout got=%b exp=1", last_cout); end
    endtask

    task automatic test_rotation();
        int n = 0;
        acc_log.delete();
        grant_log.delete();
        tick_drive();
        keep_valid = 1;
        for (int i = 0; i < NREQ; i++) new_data(i);
        req_valid = '1;
        rsp_ready = 1'b1;
        sample();
        while (acc_log.size() < 5 && n < 60) begin
            cycle();
            n++;
        end
        tick_drive();
        req_valid = '0;
        keep_valid = 0;
        sample();
        wait_idle(20);
        nchk++;
        if (acc_log.size() != 5) begin nerr++; $display("FAIL rotation_count got=%0d exp=5", acc_log.size()); end
        for (int k = 0; k < 5; k++) begin
            if (grant_log.size() > k) begin
                nchk++;
                if (grant_log[k] != k % NREQ) begin
                    nerr++;
                    $display("FAIL rotation_grant k=%0d got=%0d exp=%0d", k, grant_log[k], k % NREQ);
                end
            end
        end
        for (int k = 1; k < 5; k++) begin
            if (acc_log.size() > k) begin
                nchk++;
                if (acc_log[k] - acc_log[k-1] != WORDS + 2) begin
                    nerr++;
                    $display("FAIL rotation_spacing k=%0d got=%0d exp=%0d", k, acc_log[k] - acc_log[k-1], WORDS + 2);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int g;
        int n = 0;
        int held = 0;
        g = int'($urandom % NREQ);
        tick_drive();
        new_data(g);
        req_valid = '0;
        req_valid[g] = 1'b1;
        rsp_ready = 1'b0;
        keep_valid = 0;
        sample();
        tick_drive();
        for (int i = 0; i < NREQ; i++) begin
            if (i != g) begin
                new_data(i);
                req_valid[i] = 1'b1;
            end
        end
        sample();
        while (rsp_valid !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (rsp_valid === 1'b1) held++;
        end
        nchk++;
        if (held != 10) begin nerr++; $display("FAIL backpressure_hold got=%0d exp=10", held); end
        tick_drive();
        rsp_ready = 1'b1;
        sample();
        cycle();
        nchk++;
        if (acc_log.size() == 0 || acc_log[acc_log.size()-1] != hs_cyc + 1) begin
            nerr++;
            $display("FAIL backpressure_regrant got=%0d exp=%0d",
                     (acc_log.size() == 0) ? -1 : acc_log[acc_log.size()-1], hs_cyc + 1);
        end
        tick_drive();
        req_valid = '0;
        sample();
        wait_idle(20);
    endtask

    task automatic test_random();
        int start_done;
        start_done = n_done;
        keep_valid = 0;
        for (int k = 0; k < 400; k++) begin
            tick_drive();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom % 4 == 0) begin
                        new_data(i);
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom % 10 == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom % 3 != 0);
            sample();
        end
        tick_drive();
        req_valid = '0;
        rsp_ready = 1'b1;
        sample();
        wait_idle(20);
        nchk++;
        if (n_done - start_done < 20) begin
            nerr++;
            $display("FAIL random_throughput got=%0d exp>=20", n_done - start_done);
        end
    endtask

    task automatic test_reset_mid();
        run_single(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        tick_drive();
        new_data(2);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        sample();
        cycle();
        cycle();
        tick_drive();
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check_zero_outputs("reset_mid");
        busy = 0;
        rr_m = 0;
        taken = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick_drive();
        new_data(1);
        new_data(3);
        req_valid = 4'b1010;
        sample();
        wait_idle(20);
        nchk++;
        if (last_id !== 2'd1) begin nerr++; $display("FAIL reset_mid_regrant got=%0d exp=1", last_id); end
        tick_drive();
        req_valid = '0;
        sample();
    endtask

    initial begin
        test_reset();
        test_single();
        test_ripple();
        test_rotation();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
